// File: rtl/rs_age_issue_pkg.sv
// Shared widths and types for the reservation station.
// The optional macro RS_AGE_ORDER_EN selects oldest-first issue in rs_age_issue.
package rs_age_issue_pkg;
  localparam int XLEN     = 32;
  localparam int PRF      = 64;
  localparam int ROB      = 16;
  localparam int RS_DEPTH = 16;
  localparam int PW       = $clog2(PRF);
  localparam int RW       = $clog2(ROB);
  localparam int CW       = $clog2(RS_DEPTH + 1);

  typedef struct packed {
    logic [7:0]      opcode;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
  } id_ex_packet_t;

  typedef struct packed {
    logic          valid;
    logic          opa_rdy;
    logic          opb_rdy;
    logic [PW-1:0] dest_prf;
    logic [RW-1:0] rob_idx;
    id_ex_packet_t packet;
  } rs_entry_t;
endpackage

// File: rtl/rs_age_issue_if.sv
// Dispatch, CDB, flush and issue bundle between the pipeline and the reservation station.
// Used unchanged whether or not RS_AGE_ORDER_EN is defined.
interface rs_age_issue_if
  import rs_age_issue_pkg::*;
#(
  parameter int WAYS_IN  = 3,
  parameter int WAYS_OUT = 3,
  parameter int CDB_WAYS = 3,
  parameter int CNT_W    = CW
);
  logic                                flush;
  logic [CDB_WAYS-1:0]                 cdb_valid;
  logic [CDB_WAYS-1:0][PW-1:0]         cdb_prf_idx;
  logic [CDB_WAYS-1:0][XLEN-1:0]       cdb_data;
  logic [WAYS_IN-1:0]                  disp_valid;
  logic [WAYS_IN-1:0]                  disp_opa_rdy;
  logic [WAYS_IN-1:0]                  disp_opb_rdy;
  logic [WAYS_IN-1:0][PW-1:0]          disp_dest_prf;
  logic [WAYS_IN-1:0][RW-1:0]          disp_rob_idx;
  id_ex_packet_t [WAYS_IN-1:0]         disp_packet;
  logic                                disp_ready;
  logic [WAYS_OUT-1:0]                 issue_valid;
  logic [WAYS_OUT-1:0]                 issue_ready;
  id_ex_packet_t [WAYS_OUT-1:0]        issue_packet;
  logic [WAYS_OUT-1:0][PW-1:0]         issue_dest_prf;
  logic [WAYS_OUT-1:0][RW-1:0]         issue_rob_idx;
  logic [CNT_W-1:0]                    free_count;

  modport master (
    output flush, cdb_valid, cdb_prf_idx, cdb_data,
    output disp_valid, disp_opa_rdy, disp_opb_rdy, disp_dest_prf, disp_rob_idx, disp_packet,
    output issue_ready,
    input  disp_ready, issue_valid, issue_packet, issue_dest_prf, issue_rob_idx, free_count
  );

  modport slave (
    input  flush, cdb_valid, cdb_prf_idx, cdb_data,
    input  disp_valid, disp_opa_rdy, disp_opb_rdy, disp_dest_prf, disp_rob_idx, disp_packet,
    input  issue_ready,
    output disp_ready, issue_valid, issue_packet, issue_dest_prf, issue_rob_idx, free_count
  );
endinterface

// File: rtl/rs_age_issue_select.sv
// Picks up to WAYS_OUT ready entries as one-hot grants, compacted onto ports 0..n-1.
// RS_AGE_ORDER_EN: oldest-first via the age matrix; otherwise lowest index first.
module rs_age_issue_select #(
  parameter int DEPTH    = 16,
  parameter int WAYS_OUT = 3
) (
  input  logic [DEPTH-1:0]                req,
`ifdef RS_AGE_ORDER_EN
  input  logic [DEPTH-1:0][DEPTH-1:0]     age,
`endif
  output logic [WAYS_OUT-1:0][DEPTH-1:0]  grant
);
  logic [DEPTH-1:0] rem;
  logic             found;
`ifdef RS_AGE_ORDER_EN
  logic             blocked;
`endif

  always_comb begin
    rem   = req;
    grant = '0;
    found = 1'b0;
`ifdef RS_AGE_ORDER_EN
    blocked = 1'b0;
`endif
    for (int k = 0; k < WAYS_OUT; k++) begin
      found = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
`ifdef RS_AGE_ORDER_EN
        // age[j][e] set means entry j is older than entry e
        blocked = 1'b0;
        for (int j = 0; j < DEPTH; j++)
          if (rem[j] && age[j][e]) blocked = 1'b1;
        if (rem[e] && !blocked && !found) begin
          grant[k][e] = 1'b1;
          found       = 1'b1;
        end
`else
        if (rem[e] && !found) begin
          grant[k][e] = 1'b1;
          found       = 1'b1;
        end
`endif
      end
      rem = rem & ~grant[k];
    end
  end
endmodule

// File: rtl/rs_age_issue.sv
// Parametrised reservation station: multi-lane dispatch, CDB wakeup, backpressured issue, flush.
// Define RS_AGE_ORDER_EN to issue oldest-first through a DEPTH x DEPTH age matrix.
module rs_age_issue
  import rs_age_issue_pkg::*;
#(
  parameter int DEPTH    = RS_DEPTH,
  parameter int WAYS_IN  = 3,
  parameter int WAYS_OUT = 3,
  parameter int CDB_WAYS = 3
) (
  input logic           clock,
  input logic           reset_n,
  rs_age_issue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  rs_entry_t                     ent   [DEPTH];
  rs_entry_t                     ent_n [DEPTH];
  logic [CNT_W-1:0]              free_count, free_count_n, n_acc, n_fire;
  logic                          disp_ready, found;
  logic [DEPTH-1:0]              req, fire, taken;
  logic [WAYS_OUT-1:0][DEPTH-1:0] grant;
  logic [WAYS_IN-1:0]            acc;
  logic [WAYS_IN-1:0][DEPTH-1:0] slot;
  logic                          port_go;

  // Highest matching CDB lane wins because later lanes overwrite earlier ones.
  function automatic logic [XLEN:0] wake(input logic rdy, input logic [XLEN-1:0] val,
                                         input logic [CDB_WAYS-1:0] cv,
                                         input logic [CDB_WAYS-1:0][PW-1:0] ct,
                                         input logic [CDB_WAYS-1:0][XLEN-1:0] cd);
    logic [XLEN:0] r;
    r = {rdy, val};
    if (!rdy)
      for (int c = 0; c < CDB_WAYS; c++)
        if (cv[c] && ct[c] == val[PW-1:0]) r = {1'b1, cd[c]};
    return r;
  endfunction

  always_comb
    for (int e = 0; e < DEPTH; e++)
      req[e] = ent[e].valid & ent[e].opa_rdy & ent[e].opb_rdy;

`ifdef RS_AGE_ORDER_EN
  logic [DEPTH-1:0][DEPTH-1:0] age, age_n;
  logic [DEPTH-1:0]            older;

  rs_age_issue_select #(.DEPTH(DEPTH), .WAYS_OUT(WAYS_OUT)) u_select (
    .req(req), .age(age), .grant(grant));

  // New entries are younger than every survivor and than earlier lanes of the same cycle.
  always_comb begin
    age_n = age;
    for (int e = 0; e < DEPTH; e++) older[e] = ent[e].valid & ~fire[e];
    for (int e = 0; e < DEPTH; e++)
      if (fire[e]) begin
        age_n[e] = '0;
        for (int x = 0; x < DEPTH; x++) age_n[x][e] = 1'b0;
      end
    for (int i = 0; i < WAYS_IN; i++)
      for (int s = 0; s < DEPTH; s++)
        if (slot[i][s]) begin
          age_n[s] = '0;
          for (int x = 0; x < DEPTH; x++) age_n[x][s] = older[x];
          older[s] = 1'b1;
        end
    if (bus.flush) age_n = '0;
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) age <= '0;
    else          age <= age_n;
`else
  rs_age_issue_select #(.DEPTH(DEPTH), .WAYS_OUT(WAYS_OUT)) u_select (
    .req(req), .grant(grant));
`endif

  always_comb begin
    fire    = '0;
    port_go = 1'b0;
    for (int k = 0; k < WAYS_OUT; k++) begin
      bus.issue_valid[k]    = (|grant[k]) & ~bus.flush;
      bus.issue_packet[k]   = '0;
      bus.issue_dest_prf[k] = '0;
      bus.issue_rob_idx[k]  = '0;
      for (int e = 0; e < DEPTH; e++)
        if (grant[k][e]) begin
          bus.issue_packet[k]   = ent[e].packet;
          bus.issue_dest_prf[k] = ent[e].dest_prf;
          bus.issue_rob_idx[k]  = ent[e].rob_idx;
        end
      port_go = (|grant[k]) & ~bus.flush & bus.issue_ready[k];
      fire    = fire | (grant[k] & {DEPTH{port_go}});
    end
  end

  // Allocation only looks at registered valid, so slots freed this cycle wait a cycle.
  always_comb begin
    taken  = '0;
    slot   = '0;
    found  = 1'b0;
    n_acc  = '0;
    n_fire = '0;
    for (int i = 0; i < WAYS_IN; i++) begin
      acc[i] = bus.disp_valid[i] & disp_ready & ~bus.flush;
      found  = 1'b0;
      for (int e = 0; e < DEPTH; e++)
        if (acc[i] && !found && !ent[e].valid && !taken[e]) begin
          slot[i][e] = 1'b1;
          taken[e]   = 1'b1;
          found      = 1'b1;
        end
      if (acc[i]) n_acc = n_acc + CNT_W'(1);
    end
    for (int e = 0; e < DEPTH; e++)
      if (fire[e]) n_fire = n_fire + CNT_W'(1);
    free_count_n = bus.flush ? CNT_W'(DEPTH) : free_count - n_acc + n_fire;
  end

  always_comb
    for (int e = 0; e < DEPTH; e++) begin
      ent_n[e] = ent[e];
      {ent_n[e].opa_rdy, ent_n[e].packet.rs1_value} =
        wake(ent[e].opa_rdy, ent[e].packet.rs1_value, bus.cdb_valid, bus.cdb_prf_idx, bus.cdb_data);
      {ent_n[e].opb_rdy, ent_n[e].packet.rs2_value} =
        wake(ent[e].opb_rdy, ent[e].packet.rs2_value, bus.cdb_valid, bus.cdb_prf_idx, bus.cdb_data);
      if (fire[e]) ent_n[e].valid = 1'b0;
      for (int i = 0; i < WAYS_IN; i++)
        if (slot[i][e]) begin
          ent_n[e].valid    = 1'b1;
          ent_n[e].dest_prf = bus.disp_dest_prf[i];
          ent_n[e].rob_idx  = bus.disp_rob_idx[i];
          ent_n[e].packet   = bus.disp_packet[i];
          {ent_n[e].opa_rdy, ent_n[e].packet.rs1_value} =
            wake(bus.disp_opa_rdy[i], bus.disp_packet[i].rs1_value,
                 bus.cdb_valid, bus.cdb_prf_idx, bus.cdb_data);
          {ent_n[e].opb_rdy, ent_n[e].packet.rs2_value} =
            wake(bus.disp_opb_rdy[i], bus.disp_packet[i].rs2_value,
                 bus.cdb_valid, bus.cdb_prf_idx, bus.cdb_data);
        end
      if (bus.flush) ent_n[e].valid = 1'b0;
    end

  // Only the valid bits and counters need reset; payload is don't-care while invalid.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int e = 0; e < DEPTH; e++) ent[e].valid <= 1'b0;
      free_count <= CNT_W'(DEPTH);
      disp_ready <= 1'b1;
    end else begin
      for (int e = 0; e < DEPTH; e++) ent[e] <= ent_n[e];
      free_count <= free_count_n;
      disp_ready <= (free_count_n >= CNT_W'(WAYS_IN));
    end

  assign bus.free_count = free_count;
  assign bus.disp_ready = disp_ready;

  assert property (@(posedge clock) disable iff (!reset_n) free_count <= CNT_W'(DEPTH));
endmodule
